// File: rtl/peak_level_meter.sv
// peak_level_meter: peak-hold level meter with linear decay; clip detector built only with PEAK_METER_CLIP_DETECT_EN.
module peak_level_meter #(
  parameter logic [15:0] TICK_DIV   = 16'd50000,
  parameter logic [7:0]  HOLD_TICKS = 8'd20,
  parameter logic [7:0]  DECAY_STEP = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic [7:0] level,
  output logic       clip
);
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
  state_t      state_q, state_d;
  logic [7:0]  level_q, level_d, hold_q, hold_d, mag, scaled;
  logic [15:0] pre_q, pre_d;
  logic        tick, capture;
  always_comb begin
    mag = sample[7] ? ~sample + 8'd1 : sample;
    scaled = (mag == 8'd128) ? 8'd255 : {mag[6:0], 1'b0};
    tick = pre_q == TICK_DIV - 16'd1;
    capture = sample_valid && scaled != 8'd0 && scaled >= level_q;
    pre_d = (capture || tick) ? 16'd0 : pre_q + 16'd1;
    state_d = state_q;
    level_d = level_q;
    hold_d = hold_q;
    if (capture) begin
      state_d = HOLD;
      level_d = scaled;
      hold_d = HOLD_TICKS;
    end else if (tick && state_q == HOLD) begin
      hold_d = hold_q - 8'd1;
      state_d = (hold_q == 8'd1) ? DECAY : HOLD;
    end else if (tick && state_q == DECAY) begin
      level_d = (level_q > DECAY_STEP) ? level_q - DECAY_STEP : 8'd0;
      state_d = (level_q > DECAY_STEP) ? DECAY : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= 8'd0;
      hold_q <= 8'd0;
      pre_q <= 16'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q <= hold_d;
      pre_q <= pre_d;
    end
  end
  assign level = level_q;
`ifdef PEAK_METER_CLIP_DETECT_EN
  // Clip window runs on its own cycle counter so its length never depends on the level prescaler phase.
  localparam logic [23:0] CLIP_CYCLES = 24'(HOLD_TICKS) * 24'(TICK_DIV);
  logic [23:0] clip_cnt_q, clip_cnt_d;
  always_comb
    clip_cnt_d = (sample_valid && (sample == 8'h7F || sample == 8'h80)) ? CLIP_CYCLES :
                 (clip_cnt_q != 24'd0) ? clip_cnt_q - 24'd1 : 24'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) clip_cnt_q <= 24'd0;
    else clip_cnt_q <= clip_cnt_d;
  end
  assign clip = clip_cnt_q != 24'd0;
`else
  assign clip = 1'b0;
`endif
endmodule

// File: tb/tb_peak_level_meter.sv
// tb_peak_level_meter: directed scoreboard bench for peak_level_meter (TICK_DIV=4, HOLD_TICKS=2, DECAY_STEP=16).
module tb_peak_level_meter;
`ifdef PEAK_METER_CLIP_DETECT_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif
  typedef struct {int id; logic [7:0] lv; logic cl;} exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0, clip;
  logic [7:0] sample = 8'd0, level;
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0, failures = 0, test_id = 0;

  peak_level_meter #(.TICK_DIV(16'd4), .HOLD_TICKS(8'd2), .DECAY_STEP(8'd16)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid), .level(level), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [7:0] s, input logic v, input logic r, input logic [7:0] el, input logic ec);
    exp_t e;
    @(negedge clk);
    sample = s;
    sample_valid = v;
    rst_n = r;
    @(posedge clk);
    e.id = test_id;
    e.lv = el;
    e.cl = ec;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [7:0] el, input logic ec);
    repeat (n) cyc(8'd0, 1'b0, 1'b1, el, ec);
  endtask

  task automatic decay(input int top, input int k0);
    int lv;
    for (int k = k0; k <= 32; k++) begin
      lv = top - 16 * k;
      if (lv < 0) lv = 0;
      idle(4, 8'(lv), 1'b0);
      if (lv == 0) break;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (level !== mon_e.lv || clip !== mon_e.cl) begin
        failures++;
        $display("FAIL test%0d t=%0t level=%0d clip=%b expected level=%0d clip=%b",
                 mon_e.id, $time, level, clip, mon_e.lv, mon_e.cl);
      end
    end
  end

  initial begin
    test_id = 1;
    repeat (3) cyc(8'($urandom), 1'b1, 1'b0, 8'd0, 1'b0);
    idle(5, 8'd0, 1'b0);
    test_id = 2;
    cyc(8'd64, 1'b1, 1'b1, 8'd128, 1'b0);
    idle(11, 8'd128, 1'b0);
    decay(128, 1);
    test_id = 3;
    cyc(8'h80, 1'b1, 1'b1, 8'd255, CE);
    idle(7, 8'd255, CE);
    idle(4, 8'd255, 1'b0);
    idle(1, 8'd239, 1'b0);
    cyc(8'hF6, 1'b1, 1'b1, 8'd239, 1'b0);
    idle(2, 8'd239, 1'b0);
    decay(255, 2);
    cyc(8'd5, 1'b1, 1'b1, 8'd10, 1'b0);
    idle(11, 8'd10, 1'b0);
    idle(3, 8'd0, 1'b0);
    test_id = 4;
    cyc(8'd40, 1'b1, 1'b1, 8'd80, 1'b0);
    idle(3, 8'd80, 1'b0);
    cyc(8'd40, 1'b1, 1'b1, 8'd80, 1'b0);
    idle(11, 8'd80, 1'b0);
    decay(80, 1);
    test_id = 5;
    cyc(8'd32, 1'b1, 1'b1, 8'd64, 1'b0);
    idle(11, 8'd64, 1'b0);
    idle(1, 8'd48, 1'b0);
    cyc(8'd10, 1'b1, 1'b1, 8'd48, 1'b0);
    cyc(8'd30, 1'b1, 1'b1, 8'd60, 1'b0);
    idle(11, 8'd60, 1'b0);
    decay(60, 1);
    test_id = 6;
    cyc(8'h7F, 1'b1, 1'b1, 8'd254, CE);
    idle(3, 8'd254, CE);
    cyc(8'h80, 1'b1, 1'b1, 8'd255, CE);
    idle(7, 8'd255, CE);
    idle(4, 8'd255, 1'b0);
    decay(255, 1);
    test_id = 7;
    cyc(8'd64, 1'b1, 1'b1, 8'd128, 1'b0);
    cyc(8'h7F, 1'b1, 1'b0, 8'd0, 1'b0);
    idle(6, 8'd0, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peak_level_meter.md
# peak_level_meter

Peak-hold level meter that turns a stream of signed 8-bit audio samples into an unsigned 8-bit level word. The level word feeds the LED bar-graph driver directly; the driver uses only `level[7:4]`. Level changes are two-sided: new peaks are captured immediately, held for a fixed time, then decay linearly to zero. The result is a readable bar display instead of flicker.

## Interface
Parameters:
- `TICK_DIV`, 16'd50000: clock cycles per meter tick (≥2).
- `HOLD_TICKS`, 8'd20: ticks a captured peak is held before decay begins (≥1).
- `DECAY_STEP`, 8'd16: amount subtracted from `level` per tick while decaying (≥1).

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `sample`, input, 8: signed two's-complement audio sample.
- `sample_valid`, input, 1: qualifies `sample` for one cycle. There is no backpressure; the block accepts a sample every cycle.
- `level`, output, 8: registered unsigned meter level, which goes to the LED driver input.
- `clip`, output, 1: clip indicator (see Configuration).

## Operation
- **Magnitude:**
  - `mag = |sample|`, range 0..128.
  - `scaled = (mag == 128) ? 255 : mag << 1`, computed 8 bits wide with no overflow.
- **Prescaler:** counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is high in the cycle the count equals `TICK_DIV`-1.
  - The prescaler is cleared to 0 on every peak capture, so tick phase is always relative to the last capture.
- **Capture condition:** `sample_valid && scaled >= level`. On capture:
  - `level <= scaled`
  - `hold_cnt <= HOLD_TICKS`
  - prescaler cleared
  - state goes to HOLD
- **States:**
  - IDLE: `level` = 0.
    - Capture with `scaled` > 0 → HOLD.
    - A sample with `scaled` = 0 is ignored; the state stays IDLE.
  - HOLD:
    - Capture takes priority (reload).
    - Otherwise, on `tick`, `hold_cnt` decrements.
    - On the tick where `hold_cnt` is 1, `hold_cnt` becomes 0 and the state goes to DECAY.
  - DECAY:
    - Capture takes priority → HOLD.
    - Otherwise, on `tick`, `level <= (level > DECAY_STEP) ? level - DECAY_STEP : 0`.
    - When the result is 0 → IDLE.
- **Simultaneous events:** a capture and a `tick` in the same cycle means the capture wins and the tick is discarded.
- **Non-capturing samples:** a sample with `scaled < level` has no effect in any state.
- **Reset:** asserting `rst_n` = 0 mid-operation wins over everything. On reset:
  - state goes to IDLE
  - `level`, `hold_cnt`, the prescaler and `clip` go to 0
  - any sample presented in that cycle is dropped

## Timing
- Reset values: `level` = 8'd0, `clip` = 0, state IDLE.
- **Capture latency:** 1 cycle. `sample_valid` at edge N gives the new `level` visible after edge N.
- **Hold duration:** exactly `HOLD_TICKS`×`TICK_DIV` cycles from capture to the DECAY transition, when there are no further captures.
- **First decrement:** happens `TICK_DIV` cycles after entering DECAY. Further decrements follow every `TICK_DIV` cycles.
- **Level monotonicity:** `level` never increases except on capture. It changes at most once per cycle.

## Configuration
- `PEAK_METER_CLIP_DETECT_EN` defined:
  - `clip` asserts the cycle after any valid `sample` equal to 8'h7F or 8'h80.
  - `clip` stays high for `HOLD_TICKS` ticks, counted with its own counter that is reloaded on every further clip sample.
  - `clip` is independent of `level` capture.
- Macro undefined:
  - the clip logic is not compiled
  - `clip` is tied to 0
  - `level` behaviour is identical

## Test plan
Bench parameters: `TICK_DIV`=4, `HOLD_TICKS`=2, `DECAY_STEP`=16.
1. **Reset:** hold `rst_n` low 3 cycles with random samples → `level`=0, `clip`=0 throughout. Release; no samples → `level` stays 0.
2. **Capture, hold and decay:** `sample`=8'd64, valid 1 cycle → `level`=128 next cycle, held for 8 cycles. Then 112, 96, … 16, 0, stepping every 4 cycles, then IDLE.
3. **Negative full-scale and saturating decay:**
   - `sample`=8'h80 → `level`=255.
   - `sample`=8'hF6 (−10) during decay, so `scaled`=20 < `level` → ignored.
   - Separately, start from `level`=10 in DECAY → next tick `level`=0.
4. **Retrigger and simultaneous event:** capture 8'd40 (`level` 80). Present 8'd40 again on the exact cycle `tick` fires in HOLD → `level` stays 80, hold restarts, and a full 8 cycles elapse before decay.
5. **Capture during decay:** in DECAY at `level`=48, sample 8'd30 → `level`=60 and HOLD. At `level`=48, sample 8'd10 → ignored.
6. **Clip, with and without the macro:**
   - Defined: `sample`=8'h7F → `clip`=1 the next cycle for 8 cycles. A second 8'h80 mid-window extends it.
   - Undefined: same stimulus → `clip`=0.
